// File: rtl/fulladder4_pkg.sv
// Shared constants and bit-level helpers for the registered ripple-carry adder.
package fulladder4_pkg;

  localparam int ADD_W = 4;

  // Majority of three inputs: the carry-out of a single full-adder stage.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/fulladder4_if.sv
// Operand/result bundle for fulladder4; master drives operands, slave returns the result.
interface fulladder4_if
  import fulladder4_pkg::*;
#(
  parameter int WIDTH = ADD_W
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output a, output b, output cin, input sum, input cout);
  modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/fulladder4_full_adder_1b.sv
// Purely combinational 1-bit full adder; one link of the ripple-carry chain.
module full_adder_1b
  import fulladder4_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = maj3(a, b, ci);

endmodule

// File: rtl/fulladder4.sv
// Registered unsigned adder: {cout,sum} <= a + b + cin through a ripple-carry chain, 1-cycle latency.
module fulladder4
  import fulladder4_pkg::*;
#(
  parameter int WIDTH = ADD_W
)(
  input  logic         clk,
  input  logic         rst,
  fulladder4_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_1b u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];

  // Output register stage: result of the combinational chain captured each edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_fulladder4.sv
// Self-checking bench for fulladder4: arithmetic reference model plus directed literal checks.
module tb_fulladder4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [4:0] exp_res;

  fulladder4_if #(.WIDTH(4)) bus ();

  fulladder4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {cout,sum}=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the result register holds a+b+cin of the last edge, or 0 on a reset edge.
  always @(posedge clk) begin
    if (rst) exp_res = 5'd0;
    else     exp_res = 5'(int'(bus.a) + int'(bus.b) + int'(bus.cin));
    #1;
    chk("model", {bus.cout, bus.sum}, exp_res);
  end

  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    rst     = r;
    bus.a   = a;
    bus.b   = b;
    bus.cin = c;
  endtask

  task automatic expect_next(input string name, input logic [4:0] exp);
    @(posedge clk);
    #2;
    chk(name, {bus.cout, bus.sum}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    bus.a   = 4'hF;
    bus.b   = 4'hF;
    bus.cin = 1'b1;

    // Reset held two edges with maximal operands
    @(posedge clk);
    expect_next("reset", 5'h00);

    drive(1'b0, 4'hF, 4'hF, 1'b1);
    expect_next("release_max", 5'h1F);

    // Exhaustive sweep, checked every edge by the model
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          drive(1'b0, 4'(x), 4'(y), 1'(c));

    drive(1'b0, 4'hF, 4'h0, 1'b1);
    expect_next("ripple_full", 5'h10);
    drive(1'b0, 4'h7, 4'h8, 1'b0);
    expect_next("ripple_none", 5'h0F);

    drive(1'b0, 4'h8, 4'h8, 1'b0);
    expect_next("overflow", 5'h10);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    expect_next("zero", 5'h00);

    // Hold: new inputs must not reach the outputs before the edge
    drive(1'b0, 4'h3, 4'h4, 1'b0);
    expect_next("hold_first", 5'h07);
    drive(1'b0, 4'h9, 4'h9, 1'b1);
    #4;
    chk("hold_before_edge", {bus.cout, bus.sum}, 5'h07);
    expect_next("hold_after_edge", 5'h13);

    // Mid-stream reset pulse
    drive(1'b0, 4'h5, 4'h6, 1'b0);
    expect_next("stream_pre", 5'h0B);
    drive(1'b1, 4'hA, 4'hA, 1'b1);
    expect_next("mid_reset", 5'h00);
    drive(1'b0, 4'h1, 4'h2, 1'b1);
    expect_next("resume", 5'h04);
    drive(1'b0, 4'hC, 4'h5, 1'b0);
    expect_next("resume_next", 5'h11);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
